adc_spi_bridge: RTL and testbench



---
 rtl/adc_bridge_pkg.sv | 51 +++++
 rtl/adc_spi_bridge_spi_frame_engine.sv | 102 ++++++++++
 rtl/adc_spi_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_adc_spi_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_bridge_pkg.sv
// -----------------------------------------------------------------------------
// adc_bridge_pkg
// Shared definitions for the ADC SPI bridge:
//   - bridge_state_t : sequencing FSM states
//   - ctrl_in / status_out bit positions
//   - ADC word geometry (12 data bits preceded by 4 leading zeros)
//   - din_bit()      : address bit driven on DIN for a given falling-edge index
// Configuration macro honoured by the bridge: ADC_AVG_EN (4-frame averaging).
// -----------------------------------------------------------------------------
package adc_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FRAME_A = 3'd1,
        ST_GAP     = 3'd2,
        ST_FRAME_D = 3'd3,
        ST_DONE    = 3'd4
    } bridge_state_t;

    // ctrl_in fields
    localparam int START_BIT = 0;
    localparam int CH_LSB    = 1;
    localparam int CH_WIDTH  = 3;
    localparam int BSEL_BIT  = 4;

    // status_out fields
    localparam int BUSY_BIT  = 8;
    localparam int DONE_BIT  = 9;

    // ADC word geometry
    localparam int ADC_BITS   = 12;
    localparam int LEAD_ZEROS = 4;

    // Averaging build: number of data frames and accumulator width
    localparam int AVG_FRAMES = 4;
    localparam int ACC_BITS   = ADC_BITS + 2;

    // The ADC reads its 3-bit channel address MSB first on falling edges 2..4
    // of the frame; every other DIN bit is a don't-care that we keep at 0.
    function automatic logic din_bit(input logic [2:0] addr, input logic [3:0] idx);
        logic b;
        case (idx)
            4'd2:    b = addr[2];
            4'd3:    b = addr[1];
            4'd4:    b = addr[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_spi_bridge_spi_frame_engine.sv
// -----------------------------------------------------------------------------
// spi_frame_engine
// Runs exactly one SPI frame of FRAME_BITS SCLK periods when frame_start pulses.
// Each period is SCLK high for CLK_DIV clocks, then low for CLK_DIV clocks.
// DIN changes together with SCLK falling; DOUT is sampled where SCLK rises.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   frame_start    : one-cycle pulse, frame begins (CS low) on the next cycle
//   addr           : channel address shifted out on DIN (latched at start)
//   cs_n, sclk, din: registered SPI outputs (idle 1 / 1 / 0)
//   sample_valid   : high in the clk cycle whose edge raises SCLK; the parent
//                    samples adc_dout at that edge
//   sample_idx     : 0-based index of the sample being taken
//   frame_done     : high in the last clk cycle of the frame (sample 15)
// -----------------------------------------------------------------------------
module spi_frame_engine
    import adc_bridge_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int FRAME_BITS = 16
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic [CH_WIDTH-1:0]           addr,
    output logic                          cs_n,
    output logic                          sclk,
    output logic                          din,
    output logic                          sample_valid,
    output logic [$clog2(FRAME_BITS)-1:0] sample_idx,
    output logic                          frame_done
);

    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic [PH_W-1:0]     phase_reg;
    logic [BIT_W-1:0]    bit_reg;
    logic [CH_WIDTH-1:0] addr_reg;
    logic                cs_n_reg;
    logic                sclk_reg;
    logic                din_reg;

    logic phase_last;
    logic bit_last;
    logic active;

    assign active     = ~cs_n_reg;
    assign phase_last = (phase_reg == PH_W'(CLK_DIV - 1));
    assign bit_last   = (bit_reg == BIT_W'(FRAME_BITS - 1));

    // sclk_reg doubles as the half-period flag: 1 = high half, 0 = low half.
    assign sample_valid = active & ~sclk_reg & phase_last;
    assign frame_done   = sample_valid & bit_last;
    assign sample_idx   = bit_reg;

    assign cs_n = cs_n_reg;
    assign sclk = sclk_reg;
    assign din  = din_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= '0;
            bit_reg   <= '0;
            addr_reg  <= '0;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b1;
            din_reg   <= 1'b0;
        end else if (frame_start) begin
            phase_reg <= '0;
            bit_reg   <= '0;
            addr_reg  <= addr;
            cs_n_reg  <= 1'b0;
            sclk_reg  <= 1'b1;
            din_reg   <= 1'b0;
        end else if (active) begin
            if (phase_last) begin
                phase_reg <= '0;
                if (sclk_reg) begin
                    // falling edge: present the next DIN bit
                    sclk_reg <= 1'b0;
                    din_reg  <= din_bit(addr_reg, 4'(bit_reg));
                end else begin
                    // rising edge: sample taken by the parent this cycle
                    sclk_reg <= 1'b1;
                    if (bit_last) begin
                        cs_n_reg <= 1'b1;
                        bit_reg  <= '0;
                        din_reg  <= 1'b0;
                    end else begin
                        bit_reg <= bit_reg + 1'b1;
                    end
                end
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_spi_bridge.sv
// -----------------------------------------------------------------------------
// adc_spi_bridge
// Bridges the SoC's 10-bit PIO pair to an 8-channel 12-bit SPI ADC
// (ADC128S022-class). A rising edge on ctrl_in[0] runs an address frame, a
// short CS-high gap and a data frame; the 12-bit result is then presented on
// status_out one byte at a time.
//
// Ports:
//   clk        : system clock (soc PIO domain)
//   reset_n    : asynchronous active-low reset
//   ctrl_in    : [0] start (rising edge), [3:1] channel, [4] byte select,
//                [9:5] ignored
//   status_out : [9] done (sticky), [8] busy, [7:0] result byte
//   adc_cs_n, adc_sclk, adc_din : SPI outputs to the ADC
//   adc_dout   : SPI serial data from the ADC
//
// Build option: define ADC_AVG_EN to run four data frames (with gaps) and
// report the truncated mean of the four conversions.
// -----------------------------------------------------------------------------
module adc_spi_bridge
    import adc_bridge_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int FRAME_BITS = 16
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] ctrl_in,
    output logic [9:0] status_out,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_din,
    input  logic       adc_dout
);

    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    bridge_state_t state_reg;
    bridge_state_t state_next;

    logic                start_d_reg;
    logic [CH_WIDTH-1:0] ch_reg;
    logic [PH_W-1:0]     gap_cnt_reg;
    logic [ADC_BITS-2:0] shift_reg;
    logic [ADC_BITS-1:0] result_reg;

    logic                start_edge;
    logic                accept;
    logic                gap_last;
    logic                frame_start;
    logic                busy;
    logic                done;
    logic                capture_done;
    logic [CH_WIDTH-1:0] frame_addr;
    logic [ADC_BITS-1:0] sample_word;

    logic                eng_sample_valid;
    logic                eng_frame_done;
    logic [BIT_W-1:0]    eng_sample_idx;

    logic                unused_ctrl;
    assign unused_ctrl = ^ctrl_in[9:5];

`ifdef ADC_AVG_EN
    logic [1:0]          frame_cnt_reg;
    logic [ACC_BITS-1:0] acc_reg;
    logic [ACC_BITS-1:0] acc_sum;
    assign acc_sum = acc_reg + ACC_BITS'(sample_word);
`endif

    assign start_edge = ctrl_in[START_BIT] & ~start_d_reg;
    assign accept     = start_edge & ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign gap_last   = (gap_cnt_reg == PH_W'(CLK_DIV - 1));

    // The engine latches its address on frame_start; at acceptance ch_reg is
    // not loaded yet, so take the channel straight from ctrl_in then.
    assign frame_addr = accept ? ctrl_in[CH_LSB +: CH_WIDTH] : ch_reg;

    // The 12th (LSB) sample is taken on the frame's last cycle, so the final
    // word is the 11 shifted bits plus the live DOUT bit.
    assign sample_word  = {shift_reg, adc_dout};
    assign capture_done = (state_reg == ST_FRAME_D) && eng_frame_done;

    spi_frame_engine #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_engine (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .addr         (frame_addr),
        .cs_n         (adc_cs_n),
        .sclk         (adc_sclk),
        .din          (adc_din),
        .sample_valid (eng_sample_valid),
        .sample_idx   (eng_sample_idx),
        .frame_done   (eng_frame_done)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) state_next = ST_FRAME_A;
            end
            ST_FRAME_A: begin
                if (eng_frame_done) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) state_next = ST_FRAME_D;
            end
            ST_FRAME_D: begin
                if (eng_frame_done) begin
`ifdef ADC_AVG_EN
                    state_next = (frame_cnt_reg == 2'(AVG_FRAMES - 1)) ? ST_DONE : ST_GAP;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        frame_start = 1'b0;
        case (state_reg)
            ST_IDLE:    frame_start = accept;
            ST_DONE: begin
                done        = 1'b1;
                frame_start = accept;
            end
            ST_FRAME_A: busy = 1'b1;
            ST_GAP: begin
                busy        = 1'b1;
                frame_start = gap_last;
            end
            ST_FRAME_D: busy = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_d_reg <= 1'b0;
            ch_reg      <= '0;
            gap_cnt_reg <= '0;
            shift_reg   <= '0;
            result_reg  <= '0;
        end else begin
            start_d_reg <= ctrl_in[START_BIT];

            if (accept) begin
                ch_reg <= ctrl_in[CH_LSB +: CH_WIDTH];
            end

            if (state_reg == ST_GAP) begin
                gap_cnt_reg <= gap_last ? '0 : gap_cnt_reg + 1'b1;
            end else begin
                gap_cnt_reg <= '0;
            end

            // Leading-zero samples are skipped; the rest shift in MSB first.
            if ((state_reg == ST_FRAME_D) && eng_sample_valid &&
                (eng_sample_idx >= BIT_W'(LEAD_ZEROS))) begin
                shift_reg <= sample_word[ADC_BITS-2:0];
            end

`ifdef ADC_AVG_EN
            if (capture_done && (frame_cnt_reg == 2'(AVG_FRAMES - 1))) begin
                result_reg <= acc_sum[ACC_BITS-1:2];
            end
`else
            if (capture_done) begin
                result_reg <= sample_word;
            end
`endif
        end
    end

`ifdef ADC_AVG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_reg <= '0;
            acc_reg       <= '0;
        end else if (accept) begin
            frame_cnt_reg <= '0;
            acc_reg       <= '0;
        end else if (capture_done) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
            acc_reg       <= acc_sum;
        end
    end
`endif

    // ---------------------------------------------------------------- status
    always_comb begin
        status_out           = '0;
        status_out[DONE_BIT] = done;
        status_out[BUSY_BIT] = busy;
        status_out[7:0]      = ctrl_in[BSEL_BIT] ? {4'h0, result_reg[ADC_BITS-1:8]}
                                                 : result_reg[7:0];
    end

endmodule

// File: tb/tb_adc_spi_bridge.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_bridge
// Self-checking bench for adc_spi_bridge with a behavioural ADC128S022 model:
// the model decodes the channel from DIN on SCLK rising edges and returns the
// previous frame's channel value on DOUT (4 lead bits, then 12 bits MSB first).
// Build with ADC_AVG_EN defined to exercise the averaging variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_spi_bridge;

    localparam int D = 25;
`ifdef ADC_AVG_EN
    localparam int NFR = 5;
    localparam int LAT = 5*32*D + 4*D;   // posedges from acceptance to done
`else
    localparam int NFR = 2;
    localparam int LAT = 2*32*D + D;
`endif

    logic       clk;
    logic       reset_n;
    logic [9:0] ctrl_in;
    logic [9:0] status_out;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic       adc_din;
    logic       adc_dout;

    int vec_cnt = 0;
    int err_cnt = 0;

    adc_spi_bridge #(.CLK_DIV(D), .FRAME_BITS(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_in    (ctrl_in),
        .status_out (status_out),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_din    (adc_din),
        .adc_dout   (adc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ ADC model
    logic [11:0] mem [8];
    logic [11:0] val_q [$];     // per-frame override values, consumed in order
    logic [2:0]  last_addr = 3'd0;
    logic [2:0]  exp_ch    = 3'd0;
    logic [15:0] tx_word   = 16'h0;
    logic [15:0] din_cap   = 16'h0;
    int          fall_idx  = 0;
    int          rise_idx  = 0;
    int          low_cnt   = 0;
    int          frames_seen = 0;
    bit          frame_open  = 1'b0;

    always @(negedge adc_cs_n) begin
        logic [11:0] v;
        if (val_q.size() > 0) v = val_q.pop_front();
        else                  v = mem[last_addr];
        // lead bits are random: the bridge must ignore them
        tx_word    = {4'($urandom), v};
        fall_idx   = 0;
        rise_idx   = 0;
        din_cap    = 16'h0;
        low_cnt    = 0;
        frame_open = 1'b1;
        frames_seen++;
    end

    always @(posedge clk) if (adc_cs_n === 1'b0) low_cnt++;

    always @(negedge adc_sclk) if (adc_cs_n === 1'b0 && fall_idx < 16) begin
        adc_dout = tx_word[15 - fall_idx];
        fall_idx++;
    end

    always @(posedge adc_sclk) if (adc_cs_n === 1'b0 && rise_idx < 16) begin
        din_cap[rise_idx] = adc_din;
        rise_idx++;
    end

    always @(posedge adc_cs_n) begin
        if (frame_open && reset_n === 1'b1) begin
            check("frame_len", low_cnt, 32*D);
            check("frame_addr", {din_cap[2], din_cap[3], din_cap[4]}, exp_ch);
            check("din_idle_bits", din_cap & ~16'h001C, 16'h0);
            last_addr = {din_cap[2], din_cap[3], din_cap[4]};
        end
        frame_open = 1'b0;
    end

    // ------------------------------------------------------------ conversion
    task automatic convert(input logic [2:0] ch, input logic [11:0] exp_res, input bit dup_start);
        int n;
        int f0;
        exp_ch = ch;
        @(negedge clk);
        ctrl_in = {5'b0, 1'b0, ch, 1'b0};
        @(negedge clk);
        f0 = frames_seen;
        ctrl_in[0] = 1'b1;
        @(negedge clk);                       // acceptance edge has passed
        check("busy_at_k1", {status_out[9:8], adc_cs_n}, 3'b010);
        ctrl_in[0] = 1'b0;
        n = 0;
        while (status_out[9] !== 1'b1 && n < LAT + 200) begin
            @(negedge clk);
            n++;
            if (dup_start && n == 499) ctrl_in[0] = 1'b1;
            if (dup_start && n == 520) ctrl_in[0] = 1'b0;
        end
        check("done_latency", n, LAT);
        check("status_lo", status_out, {2'b10, exp_res[7:0]});
        ctrl_in[4] = 1'b1;
        #1;
        check("status_hi", status_out, {2'b10, 4'h0, exp_res[11:8]});
        ctrl_in[4] = 1'b0;
        check("frame_count", frames_seen - f0, NFR);
        repeat (40) @(negedge clk);
        check("done_sticky", {status_out[9:8], adc_cs_n}, 3'b101);
        check("no_extra_frame", frames_seen - f0, NFR);
        $display("conv ch=%0d expected=%03h byte_lo=%02h latency=%0d dup=%0d",
                 ch, exp_res, status_out[7:0], n, dup_start);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [11:0] sweep_vals [8];
        logic [11:0] rv;
        logic [2:0]  rc;

        sweep_vals[0] = 12'h000; sweep_vals[1] = 12'hFFF;
        sweep_vals[2] = 12'h800; sweep_vals[3] = 12'h7FF;
        sweep_vals[4] = 12'h001; sweep_vals[5] = 12'hA5C;
        sweep_vals[6] = 12'($urandom); sweep_vals[7] = 12'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = 12'h000;

        adc_dout = 1'b0;
        ctrl_in  = 10'h000;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", adc_cs_n, 1'b1);
        check("rst_sclk", adc_sclk, 1'b1);
        check("rst_din", adc_din, 1'b0);
        check("rst_status", status_out, 10'h000);
        reset_n = 1'b1;
        $display("reset released");

        // reset asserted mid-frame
        mem[5] = 12'h3C3;
        @(negedge clk); ctrl_in = 10'h00B;     // ch5, start
        @(negedge clk); ctrl_in = 10'h00A;
        repeat (299) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_cs_n", adc_cs_n, 1'b1);
        check("midrst_sclk", adc_sclk, 1'b1);
        check("midrst_status", status_out, 10'h000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 100) @(negedge clk);
        check("post_rst_lo", status_out, 10'h000);
        ctrl_in[4] = 1'b1; #1;
        check("post_rst_hi", status_out, 10'h000);
        ctrl_in[4] = 1'b0;
        check("post_rst_cs", adc_cs_n, 1'b1);
        $display("mid-frame reset done");

        // basic conversion, then start-while-busy
        mem[3] = 12'hA5C;
        convert(3'd3, 12'hA5C, 1'b0);
        mem[6] = 12'h5A3;
        convert(3'd6, 12'h5A3, 1'b1);

        // channel sweep, back-to-back while done=1
        for (int c = 0; c < 8; c++) mem[c] = sweep_vals[c];
        for (int c = 0; c < 8; c++) convert(3'(c), sweep_vals[c], 1'b0);

        // random channel/value pairs
        for (int r = 0; r < 2; r++) begin
            rc = 3'($urandom_range(0, 7));
            rv = 12'($urandom);
            mem[rc] = rv;
            convert(rc, rv, 1'b0);
        end

`ifdef ADC_AVG_EN
        begin
            logic [11:0] s [4];
            int sum;
            s[0] = 12'h100; s[1] = 12'h101; s[2] = 12'h102; s[3] = 12'h104;
            sum = 0;
            val_q.push_back(12'h555);          // address frame, discarded
            for (int i = 0; i < 4; i++) begin val_q.push_back(s[i]); sum += s[i]; end
            convert(3'd2, 12'(sum / 4), 1'b0);
            sum = 0;
            val_q.push_back(12'h000);
            for (int i = 0; i < 4; i++) begin val_q.push_back(12'hFFF); sum += 12'hFFF; end
            convert(3'd7, 12'(sum / 4), 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
